// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, valid/ready on
// both operand and result sides, all-ones quotient and div_by_zero flag when B == 0.
module seq_divider #(
   parameter int unsigned N = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   q_q, q_d;
   logic [N:0]     r_q, r_d;
   logic [N-1:0]   bq_q, bq_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   quo_q, quo_d;
   logic [N-1:0]   rem_q, rem_d;
   logic           dbz_q, dbz_d;

   logic           accept;
   logic           b_zero;
   logic           last_step;
   logic [N:0]     partial;
   logic [N:0]     trial;

   assign accept    = (state_q == IDLE) && in_valid;
   assign b_zero    = (B == '0);
   assign last_step = (state_q == CALC) && (cnt_q == CW'(N - 1));
   assign partial   = {r_q[N-1:0], q_q[N-1]};
   assign trial     = partial - {1'b0, bq_q};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = b_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Restoring step and result capture
   always_comb begin
      q_d   = q_q;
      r_d   = r_q;
      bq_d  = bq_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dbz_d = dbz_q;

      if (accept) begin
         if (b_zero) begin
            quo_d = '1;
            rem_d = A;
            dbz_d = 1'b1;
         end else begin
            q_d   = A;
            r_d   = '0;
            bq_d  = B;
            cnt_d = '0;
         end
      end

      if (state_q == CALC) begin
         if (!trial[N]) begin
            r_d = trial;
            q_d = {q_q[N-2:0], 1'b1};
         end else begin
            r_d = partial;
            q_d = {q_q[N-2:0], 1'b0};
         end
         cnt_d = cnt_q + CW'(1);
         if (last_step) begin
            quo_d = q_d;
            rem_d = r_d[N-1:0];
            dbz_d = 1'b0;
         end
      end
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= '0;
         r_q   <= '0;
         bq_q  <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         r_q   <= r_d;
         bq_q  <= bq_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dbz_q <= dbz_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_seq_divider;

   localparam int unsigned N = 10;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;
   logic         out_valid;
   logic         out_ready;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic rand_mode = 1'b0;
   logic or_force  = 1'b1;

   seq_divider #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .A           (A),
      .B           (B),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Consumer: out_ready changes just after the rising edge
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_mode ? 1'($urandom_range(0, 1)) : or_force;
      end
   end

   // Monitor: a handshake seen at the falling edge completes on the next rising edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               check("quotient", int'(quotient), int'(e.q));
               check("remainder", int'(remainder), int'(e.r));
               check("div_by_zero", int'(div_by_zero), int'(e.dz));
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
      exp_t e;
      int   n;
      @(posedge clk);
      #1;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      e.q  = eq;
      e.r  = er;
      e.dz = edz;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = N'($urandom);
      B        = N'($urandom);
   endtask

   task automatic send_model(input logic [N-1:0] a, input logic [N-1:0] b);
      if (b == '0) send(a, b, '1, a, 1'b1);
      else         send(a, b, a / b, a % b, 1'b0);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, sb.size(), 0);
   endtask

   // Counts falling edges after the accept edge until out_valid rises
   task automatic latency(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 40);
   endtask

   initial begin
      int  n;
      logic seen;
      logic [N-1:0] a, b;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);

      // 1000 / 7 with latency and return of in_ready
      send(10'd1000, 10'd7, 10'd142, 10'd6, 1'b0);
      latency(n);
      check("latency_nonzero_b", n, N + 1);
      check("calc_in_ready_low", int'(in_ready), 0);
      @(negedge clk);
      check("in_ready_after_hs", int'(in_ready), 1);
      check("out_valid_after_hs", int'(out_valid), 0);

      // Boundary vectors back to back
      send(10'd1023, 10'd1, 10'd1023, 10'd0, 1'b0);
      send(10'd5, 10'd9, 10'd0, 10'd5, 1'b0);
      send(10'd513, 10'd513, 10'd1, 10'd0, 1'b0);
      send(10'd0, 10'd37, 10'd0, 10'd0, 1'b0);
      drain("drain_boundaries");

      // Divide by zero
      send(10'd77, 10'd0, 10'd1023, 10'd77, 1'b1);
      latency(n);
      check("latency_zero_b", n, 1);
      drain("drain_div_zero");

      // Back-pressure: outputs hold, in_valid ignored
      or_force = 1'b0;
      repeat (2) @(posedge clk);
      send(10'd600, 10'd25, 10'd24, 10'd0, 1'b0);
      latency(n);
      check("stall_out_valid", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = (i % 2 == 0);
         A        = 10'd1;
         B        = 10'd1;
         @(negedge clk);
         check("stall_quotient", int'(quotient), 24);
         check("stall_remainder", int'(remainder), 0);
         check("stall_out_valid_hold", int'(out_valid), 1);
         check("stall_in_ready", int'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      or_force = 1'b1;
      drain("drain_stall");
      repeat (3) @(negedge clk);
      check("no_ghost_accept", int'(out_valid), 0);

      // Reset during CALC abandons the operation
      send(10'd900, 10'd3, 10'd300, 10'd0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      check("midrst_quotient", int'(quotient), 0);
      check("midrst_remainder", int'(remainder), 0);
      check("midrst_div_by_zero", int'(div_by_zero), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", int'(in_ready), 1);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_result", int'(seen), 0);
      send(10'd900, 10'd3, 10'd300, 10'd0, 1'b0);
      drain("drain_after_reset");

      // Mixed operands with random gaps and random back-pressure
      rand_mode = 1'b1;
      for (int i = 0; i < 150; i++) begin
         a = N'($urandom_range(0, 1023));
         if (i % 10 == 0)     b = '0;
         else if (i % 3 == 0) b = N'($urandom_range(1, 1023));
         else                 b = N'($urandom_range(1, 40));
         send_model(a, b);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      rand_mode = 1'b0;
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
